add_unit_scheduler: RTL and testbench

Issue scheduler for the single add/sub execution unit of the Tomasulo core. Each cycle it picks one ready add reservation-station entry by round-robin and launches it into the fixed-latency add/sub datapath. It computes the result, then holds it on a common-data-bus (CDB) request until the CDB arbiter grants it. It sits between the add reservation-station array and the CDB arbiter, which is shared with the multiply unit.

---
 rtl/add_unit_scheduler.sv | 214 +++++++++++++++++++++
 tb/tb_add_unit_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/add_unit_scheduler.sv
// add_unit_scheduler
// Issue scheduler for the single add/sub execution unit. It picks one ready
// reservation-station entry by round-robin and runs it through a fixed-latency
// add/sub datapath. The result is then held on a CDB request until the
// arbiter grants it.
//
// Ports:
//   clk1, rst                    clock, asynchronous active-high reset
//   rs_valid, rs_ready           per-entry occupancy and operand-ready flags
//   rs_func/op1/op2/rob/rd       per-entry packed instruction fields
//   flush                        kills any in-flight op at the next edge
//   cdb_grant                    CDB arbiter accepts the pending result
//   rs_free_valid, rs_free_idx   one-cycle release pulse for the issued entry
//   busy                         unit is not idle
//   cdb_req, cdb_data, cdb_rob, cdb_rd, illegal   result broadcast

module add_unit_scheduler #(
  parameter int unsigned NUM_RS   = 3,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ROB_W    = 3,
  parameter int unsigned REG_W    = 4,
  parameter int unsigned EXEC_LAT = 4
) (
  input  logic                        clk1,
  input  logic                        rst,
  input  logic [NUM_RS-1:0]           rs_valid,
  input  logic [NUM_RS-1:0]           rs_ready,
  input  logic [4*NUM_RS-1:0]         rs_func,
  input  logic [DATA_W*NUM_RS-1:0]    rs_op1,
  input  logic [DATA_W*NUM_RS-1:0]    rs_op2,
  input  logic [ROB_W*NUM_RS-1:0]     rs_rob,
  input  logic [REG_W*NUM_RS-1:0]     rs_rd,
  input  logic                        flush,
  input  logic                        cdb_grant,
  output logic                        rs_free_valid,
  output logic [$clog2(NUM_RS)-1:0]   rs_free_idx,
  output logic                        busy,
  output logic                        cdb_req,
  output logic [DATA_W-1:0]           cdb_data,
  output logic [ROB_W-1:0]            cdb_rob,
  output logic [REG_W-1:0]            cdb_rd,
  output logic                        illegal
);

  localparam int unsigned IDX_W = $clog2(NUM_RS);
  localparam int unsigned CNT_W = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] WB   = 2'd2;

  localparam logic [3:0] FUNC_ADD = 4'b0000;
  localparam logic [3:0] FUNC_SUB = 4'b0001;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic             free_valid_q, free_valid_d;
  logic [IDX_W-1:0] free_idx_q, free_idx_d;

  logic [3:0]        func_q;
  logic [DATA_W-1:0] op1_q, op2_q;
  logic [ROB_W-1:0]  rob_q;
  logic [REG_W-1:0]  rd_q;

  logic [DATA_W-1:0] data_q;
  logic [ROB_W-1:0]  res_rob_q;
  logic [REG_W-1:0]  res_rd_q;
  logic              illegal_q, illegal_d;

  logic              issue, load_res;
  logic              grant_found;
  logic [IDX_W-1:0]  grant_idx;
  logic [NUM_RS-1:0] cand;
  logic [DATA_W-1:0] res;
  logic              res_ill;

  // Per-entry views of the packed input buses.
  logic [3:0]        func_arr [NUM_RS];
  logic [DATA_W-1:0] op1_arr  [NUM_RS];
  logic [DATA_W-1:0] op2_arr  [NUM_RS];
  logic [ROB_W-1:0]  rob_arr  [NUM_RS];
  logic [REG_W-1:0]  rd_arr   [NUM_RS];

  for (genvar g = 0; g < NUM_RS; g++) begin : g_unpack
    assign func_arr[g] = rs_func[4*g +: 4];
    assign op1_arr[g]  = rs_op1[DATA_W*g +: DATA_W];
    assign op2_arr[g]  = rs_op2[DATA_W*g +: DATA_W];
    assign rob_arr[g]  = rs_rob[ROB_W*g +: ROB_W];
    assign rd_arr[g]   = rs_rd[REG_W*g +: REG_W];
  end

  function automatic logic [IDX_W-1:0] wrap_idx(input int unsigned v);
    return IDX_W'(v % NUM_RS);
  endfunction

  assign cand = rs_valid & rs_ready & {NUM_RS{~flush}};

  // Round-robin: search starts one past the last granted entry, with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int unsigned k = 1; k <= NUM_RS; k++) begin
      if (!grant_found && cand[wrap_idx(32'(rr_ptr_q) + k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(32'(rr_ptr_q) + k);
      end
    end
  end

  // Datapath works on the latched operands; carry/borrow is dropped.
  always_comb begin
    res     = '0;
    res_ill = 1'b0;
    case (func_q)
      FUNC_ADD: res = op1_q + op2_q;
      FUNC_SUB: res = op1_q - op2_q;
      default:  res_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_ptr_d     = rr_ptr_q;
    free_valid_d = 1'b0;
    free_idx_d   = free_idx_q;
    illegal_d    = illegal_q;
    issue        = 1'b0;
    load_res     = 1'b0;
    if (flush) begin
      // A grant coinciding with flush still counts; either way we go idle.
      state_d   = IDLE;
      illegal_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_found) begin
            issue        = 1'b1;
            state_d      = EXEC;
            cnt_d        = CNT_W'(EXEC_LAT - 1);
            rr_ptr_d     = grant_idx;
            free_valid_d = 1'b1;
            free_idx_d   = grant_idx;
          end
        end
        EXEC: begin
          if (cnt_q == '0) begin
            state_d   = WB;
            load_res  = 1'b1;
            illegal_d = res_ill;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        WB: begin
          if (cdb_grant) begin
            state_d   = IDLE;
            illegal_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      rr_ptr_q     <= IDX_W'(NUM_RS - 1);
      free_valid_q <= 1'b0;
      free_idx_q   <= '0;
      func_q       <= '0;
      op1_q        <= '0;
      op2_q        <= '0;
      rob_q        <= '0;
      rd_q         <= '0;
      data_q       <= '0;
      res_rob_q    <= '0;
      res_rd_q     <= '0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      free_valid_q <= free_valid_d;
      free_idx_q   <= free_idx_d;
      illegal_q    <= illegal_d;
      if (issue) begin
        func_q <= func_arr[grant_idx];
        op1_q  <= op1_arr[grant_idx];
        op2_q  <= op2_arr[grant_idx];
        rob_q  <= rob_arr[grant_idx];
        rd_q   <= rd_arr[grant_idx];
      end
      if (load_res) begin
        data_q    <= res;
        res_rob_q <= rob_q;
        res_rd_q  <= rd_q;
      end
    end
  end

  assign rs_free_valid = free_valid_q;
  assign rs_free_idx   = free_idx_q;
  assign busy          = (state_q != IDLE);
  assign cdb_req       = (state_q == WB);
  assign cdb_data      = data_q;
  assign cdb_rob       = res_rob_q;
  assign cdb_rd        = res_rd_q;
  assign illegal       = illegal_q;

endmodule

// File: tb/tb_add_unit_scheduler.sv
// Directed testbench for add_unit_scheduler (NUM_RS=3, DATA_W=8, EXEC_LAT=4).
module tb_add_unit_scheduler;

  localparam int NUM_RS   = 3;
  localparam int DATA_W   = 8;
  localparam int ROB_W    = 3;
  localparam int REG_W    = 4;
  localparam int EXEC_LAT = 4;

  logic                     clk1;
  logic                     rst;
  logic [NUM_RS-1:0]        rs_valid;
  logic [NUM_RS-1:0]        rs_ready;
  logic [4*NUM_RS-1:0]      rs_func;
  logic [DATA_W*NUM_RS-1:0] rs_op1;
  logic [DATA_W*NUM_RS-1:0] rs_op2;
  logic [ROB_W*NUM_RS-1:0]  rs_rob;
  logic [REG_W*NUM_RS-1:0]  rs_rd;
  logic                     flush;
  logic                     cdb_grant;
  logic                     rs_free_valid;
  logic [1:0]               rs_free_idx;
  logic                     busy;
  logic                     cdb_req;
  logic [DATA_W-1:0]        cdb_data;
  logic [ROB_W-1:0]         cdb_rob;
  logic [REG_W-1:0]         cdb_rd;
  logic                     illegal;

  int checks;
  int failures;

  add_unit_scheduler #(
    .NUM_RS  (NUM_RS),
    .DATA_W  (DATA_W),
    .ROB_W   (ROB_W),
    .REG_W   (REG_W),
    .EXEC_LAT(EXEC_LAT)
  ) dut (
    .clk1         (clk1),
    .rst          (rst),
    .rs_valid     (rs_valid),
    .rs_ready     (rs_ready),
    .rs_func      (rs_func),
    .rs_op1       (rs_op1),
    .rs_op2       (rs_op2),
    .rs_rob       (rs_rob),
    .rs_rd        (rs_rd),
    .flush        (flush),
    .cdb_grant    (cdb_grant),
    .rs_free_valid(rs_free_valid),
    .rs_free_idx  (rs_free_idx),
    .busy         (busy),
    .cdb_req      (cdb_req),
    .cdb_data     (cdb_data),
    .cdb_rob      (cdb_rob),
    .cdb_rd       (cdb_rd),
    .illegal      (illegal)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic set_entry(input int i, input logic [3:0] f, input logic [7:0] a,
                           input logic [7:0] b, input logic [2:0] rob, input logic [3:0] rd);
    rs_func[4*i +: 4]       = f;
    rs_op1[DATA_W*i +: 8]   = a;
    rs_op2[DATA_W*i +: 8]   = b;
    rs_rob[ROB_W*i +: 3]    = rob;
    rs_rd[REG_W*i +: 4]     = rd;
    rs_valid[i]             = 1'b1;
    rs_ready[i]             = 1'b1;
  endtask

  task automatic clear_entries();
    rs_valid = '0;
    rs_ready = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_free_valid"}, 32'(rs_free_valid), 0);
    check_eq({tag, "_free_idx"},   32'(rs_free_idx),   0);
    check_eq({tag, "_busy"},       32'(busy),          0);
    check_eq({tag, "_cdb_req"},    32'(cdb_req),       0);
    check_eq({tag, "_cdb_data"},   32'(cdb_data),      0);
    check_eq({tag, "_cdb_rob"},    32'(cdb_rob),       0);
    check_eq({tag, "_cdb_rd"},     32'(cdb_rd),        0);
    check_eq({tag, "_illegal"},    32'(illegal),       0);
  endtask

  // Full op with cdb_grant held high; starts and ends in IDLE.
  task automatic do_op(input string tag, input int entry, input logic [3:0] f,
                       input logic [7:0] a, input logic [7:0] b, input logic [2:0] rob,
                       input logic [3:0] rd, input logic [7:0] exp_data, input logic exp_ill);
    set_entry(entry, f, a, b, rob, rd);
    tick();  // E0
    check_eq({tag, "_free_pulse"}, 32'(rs_free_valid), 1);
    check_eq({tag, "_free_idx"},   32'(rs_free_idx),   32'(entry));
    check_eq({tag, "_busy"},       32'(busy),          1);
    clear_entries();
    tick();  // E1
    check_eq({tag, "_pulse_once"}, 32'(rs_free_valid), 0);
    tick();
    tick();  // E3
    check_eq({tag, "_req_early"},  32'(cdb_req),       0);
    tick();  // E4
    check_eq({tag, "_req"},        32'(cdb_req),       1);
    check_eq({tag, "_data"},       32'(cdb_data),      32'(exp_data));
    check_eq({tag, "_rob"},        32'(cdb_rob),       32'(rob));
    check_eq({tag, "_rd"},         32'(cdb_rd),        32'(rd));
    check_eq({tag, "_illegal"},    32'(illegal),       32'(exp_ill));
    tick();  // granted in first WB cycle
    check_eq({tag, "_req_drop"},   32'(cdb_req),       0);
    check_eq({tag, "_idle"},       32'(busy),          0);
  endtask

  int pulse_cyc[$];
  int pulse_idx[$];
  int exp_rr[4] = '{0, 1, 2, 0};

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    rs_valid  = '0;
    rs_ready  = '0;
    rs_func   = '0;
    rs_op1    = '0;
    rs_op2    = '0;
    rs_rob    = '0;
    rs_rd     = '0;
    flush     = 1'b0;
    cdb_grant = 1'b1;
    #1;
    check_all_zero("reset");
    tick();
    tick();
    rst = 1'b0;

    do_op("add",  1, 4'b0000, 8'h2A, 8'h15, 3'd5, 4'd3, 8'h3F, 1'b0);
    do_op("sub",  2, 4'b0001, 8'h03, 8'h05, 3'd1, 4'd7, 8'hFE, 1'b0);
    do_op("wrap", 0, 4'b0000, 8'hFF, 8'h02, 3'd2, 4'd4, 8'h01, 1'b0);
    do_op("ill",  1, 4'b0111, 8'h12, 8'h34, 3'd6, 4'd9, 8'h00, 1'b1);

    // Round-robin with all entries ready after a fresh reset.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_entry(0, 4'b0000, 8'h01, 8'h01, 3'd0, 4'd0);
    set_entry(1, 4'b0000, 8'h02, 8'h02, 3'd1, 4'd1);
    set_entry(2, 4'b0000, 8'h03, 8'h03, 3'd2, 4'd2);
    for (int c = 1; c <= 24; c++) begin
      tick();
      if (rs_free_valid) begin
        pulse_cyc.push_back(c);
        pulse_idx.push_back(int'(rs_free_idx));
      end
    end
    clear_entries();
    check_eq("rr_count", 32'(pulse_cyc.size()), 4);
    for (int i = 0; i < pulse_cyc.size() && i < 4; i++) begin
      check_eq($sformatf("rr_idx%0d", i), 32'(pulse_idx[i]), 32'(exp_rr[i]));
      if (i > 0) begin
        check_eq($sformatf("rr_gap%0d", i), 32'(pulse_cyc[i] - pulse_cyc[i-1]),
                 32'(EXEC_LAT + 2));
      end
    end

    // Stall in WB: grant withheld for 5 cycles, given in cycle 6.
    cdb_grant = 1'b0;
    set_entry(2, 4'b0001, 8'h10, 8'h01, 3'd3, 4'd2);
    tick();
    check_eq("hold_idx", 32'(rs_free_idx), 2);
    clear_entries();
    for (int i = 0; i < EXEC_LAT; i++) tick();
    for (int n = 1; n <= 5; n++) begin
      check_eq($sformatf("hold_req%0d", n),  32'(cdb_req),  1);
      check_eq($sformatf("hold_data%0d", n), 32'(cdb_data), 32'h0F);
      tick();
    end
    check_eq("hold_req6", 32'(cdb_req), 1);
    check_eq("hold_rob6", 32'(cdb_rob), 3);
    cdb_grant = 1'b1;
    tick();
    check_eq("hold_release", 32'(cdb_req), 0);
    check_eq("hold_idle",    32'(busy),    0);

    // Flush in EXEC with cnt=2; next issue resumes past the flushed entry.
    set_entry(0, 4'b0000, 8'h05, 8'h06, 3'd7, 4'd1);
    set_entry(1, 4'b0000, 8'h11, 8'h22, 3'd4, 4'd5);
    tick();  // E0, entry 0
    check_eq("flush_issue_idx", 32'(rs_free_idx), 0);
    tick();  // E1: cnt now 2
    flush = 1'b1;
    tick();
    check_eq("flush_busy",  32'(busy),          0);
    check_eq("flush_req",   32'(cdb_req),       0);
    check_eq("flush_pulse", 32'(rs_free_valid), 0);
    flush = 1'b0;
    tick();
    check_eq("post_flush_pulse", 32'(rs_free_valid), 1);
    check_eq("post_flush_idx",   32'(rs_free_idx),   1);
    clear_entries();
    cdb_grant = 1'b0;
    for (int i = 0; i < EXEC_LAT; i++) tick();
    check_eq("pre_rst_req",  32'(cdb_req),  1);
    check_eq("pre_rst_data", 32'(cdb_data), 32'h33);

    // Asynchronous reset mid-cycle while in WB.
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("async_rst");
    tick();
    rst = 1'b0;
    cdb_grant = 1'b1;
    set_entry(0, 4'b0000, 8'h01, 8'h02, 3'd1, 4'd1);
    set_entry(2, 4'b0000, 8'h03, 8'h04, 3'd2, 4'd2);
    tick();
    check_eq("rst_prio_pulse", 32'(rs_free_valid), 1);
    check_eq("rst_prio_idx",   32'(rs_free_idx),   0);
    clear_entries();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
